// File: rtl/alsu_arb_ctrl.sv
// rtl/alsu_arb_ctrl.sv - round-robin arbiter sharing one ALSU between requesters, one command in flight.
// Optional ALSU_LOCK_EN adds req_lock so a requester can keep the ALSU across back-to-back commands.
module alsu_arb_ctrl #(
    parameter int         NUM_REQ     = 2,
    parameter int         LAT         = 2,
    parameter logic [2:0] IDLE_OPCODE = 3'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_cmd,
`ifdef ALSU_LOCK_EN
    input  logic [NUM_REQ-1:0]      req_lock,
`endif
    output logic [2:0]              alsu_opcode,
    output logic [2:0]              alsu_A,
    output logic [2:0]              alsu_B,
    output logic                    alsu_cin,
    output logic                    alsu_serial_in,
    output logic                    alsu_direction,
    output logic                    alsu_red_op_A,
    output logic                    alsu_red_op_B,
    output logic                    alsu_bypass_A,
    output logic                    alsu_bypass_B,
    input  logic [5:0]              alsu_out,
    input  logic [15:0]             alsu_leds,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_id,
    output logic [5:0]              rsp_out,
    output logic [15:0]             rsp_leds,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_rr_ptr;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_id;
    logic               r_err;

    logic [2:0]         r_alsu_opcode;
    logic [2:0]         r_alsu_A;
    logic [2:0]         r_alsu_B;
    logic               r_alsu_cin;
    logic               r_alsu_serial_in;
    logic               r_alsu_direction;
    logic               r_alsu_red_op_A;
    logic               r_alsu_red_op_B;
    logic               r_alsu_bypass_A;
    logic               r_alsu_bypass_B;

    logic               r_rsp_valid;
    logic [1:0]         r_rsp_id;
    logic [5:0]         r_rsp_out;
    logic [15:0]        r_rsp_leds;
    logic               r_rsp_err;
    logic               r_busy;

    logic [2*NUM_REQ-1:0] w_valid_dbl;
    logic [NUM_REQ-1:0]   w_valid_rot;
    logic [1:0]           w_rot_off;
    logic                 w_rr_vld;
    logic [2:0]           w_grant_sum;
    logic [1:0]           w_rr_grant;
    logic [1:0]           w_grant;
    logic                 w_grant_vld;
    logic [1:0]           w_rr_nxt;
    logic                 w_req_hs;
    logic                 w_rsp_hs;
    logic                 w_last_wait;
    logic [15:0]          w_cmd;
    logic                 w_err;

    // Rotate the valid vector so bit 0 is the rr pointer; the lowest set bit is the grant offset.
    assign w_valid_dbl = {req_valid, req_valid};
    assign w_valid_rot = NUM_REQ'(w_valid_dbl >> r_rr_ptr);

    always_comb begin
        w_rot_off = 2'd0;
        w_rr_vld  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
                w_rot_off = 2'(k);
                w_rr_vld  = 1'b1;
            end
        end
    end

    assign w_grant_sum = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
    assign w_rr_grant  = (w_grant_sum >= 3'(NUM_REQ)) ? 2'(w_grant_sum - 3'(NUM_REQ))
                                                      : w_grant_sum[1:0];

`ifdef ALSU_LOCK_EN
    logic       r_lock_act;
    logic [1:0] r_lock_id;
    logic       w_lock_valid;
    logic       w_lock_req;

    assign w_lock_valid = 1'(req_valid >> r_lock_id);
    assign w_lock_req   = 1'(req_lock >> r_rsp_id);
    assign w_grant      = r_lock_act ? r_lock_id    : w_rr_grant;
    assign w_grant_vld  = r_lock_act ? w_lock_valid : w_rr_vld;
`else
    assign w_grant      = w_rr_grant;
    assign w_grant_vld  = w_rr_vld;
`endif

    assign w_rr_nxt    = (w_grant == 2'(NUM_REQ - 1)) ? 2'd0 : w_grant + 2'd1;
    assign w_req_hs    = (r_state == S_IDLE) && w_grant_vld;
    assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready;
    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == CW'(1));

    assign req_ready = w_req_hs ? (ONE_HOT0 << w_grant) : '0;

    assign w_cmd = 16'(req_cmd >> {w_grant, 4'b0000});
    // Only AND/XOR support the reduction modes; opcodes 6 and 7 are invalid on the ALSU.
    assign w_err = (w_cmd[2:0] >= 3'd6) | ((w_cmd[12] | w_cmd[13]) & (w_cmd[2:1] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_DRIVE;
            S_DRIVE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr         <= 2'd0;
            r_cnt            <= '0;
            r_id             <= 2'd0;
            r_err            <= 1'b0;
            r_alsu_opcode    <= IDLE_OPCODE;
            r_alsu_A         <= 3'd0;
            r_alsu_B         <= 3'd0;
            r_alsu_cin       <= 1'b0;
            r_alsu_serial_in <= 1'b0;
            r_alsu_direction <= 1'b0;
            r_alsu_red_op_A  <= 1'b0;
            r_alsu_red_op_B  <= 1'b0;
            r_alsu_bypass_A  <= 1'b0;
            r_alsu_bypass_B  <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_id         <= 2'd0;
            r_rsp_out        <= 6'd0;
            r_rsp_leds       <= 16'd0;
            r_rsp_err        <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);

            // ALSU pins idle every cycle except the single DRIVE cycle loaded below.
            r_alsu_opcode    <= IDLE_OPCODE;
            r_alsu_A         <= 3'd0;
            r_alsu_B         <= 3'd0;
            r_alsu_cin       <= 1'b0;
            r_alsu_serial_in <= 1'b0;
            r_alsu_direction <= 1'b0;
            r_alsu_red_op_A  <= 1'b0;
            r_alsu_red_op_B  <= 1'b0;
            r_alsu_bypass_A  <= 1'b0;
            r_alsu_bypass_B  <= 1'b0;

            if (w_req_hs) begin
                r_alsu_opcode    <= w_cmd[2:0];
                r_alsu_A         <= w_cmd[5:3];
                r_alsu_B         <= w_cmd[8:6];
                r_alsu_cin       <= w_cmd[9];
                r_alsu_serial_in <= w_cmd[10];
                r_alsu_direction <= w_cmd[11];
                r_alsu_red_op_A  <= w_cmd[12];
                r_alsu_red_op_B  <= w_cmd[13];
                r_alsu_bypass_A  <= w_cmd[14];
                r_alsu_bypass_B  <= w_cmd[15];
                r_id             <= w_grant;
                r_err            <= w_err;
                r_rr_ptr         <= w_rr_nxt;
            end

            if (r_state == S_DRIVE) begin
                r_cnt <= CW'(LAT);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_last_wait) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_out   <= alsu_out;
                r_rsp_leds  <= alsu_leds;
                r_rsp_err   <= r_err;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALSU_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_act <= 1'b0;
            r_lock_id  <= 2'd0;
        end else if (w_rsp_hs) begin
            r_lock_act <= w_lock_req;
            r_lock_id  <= r_rsp_id;
        end
    end
`endif

    assign alsu_opcode    = r_alsu_opcode;
    assign alsu_A         = r_alsu_A;
    assign alsu_B         = r_alsu_B;
    assign alsu_cin       = r_alsu_cin;
    assign alsu_serial_in = r_alsu_serial_in;
    assign alsu_direction = r_alsu_direction;
    assign alsu_red_op_A  = r_alsu_red_op_A;
    assign alsu_red_op_B  = r_alsu_red_op_B;
    assign alsu_bypass_A  = r_alsu_bypass_A;
    assign alsu_bypass_B  = r_alsu_bypass_B;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_out        = r_rsp_out;
    assign rsp_leds       = r_rsp_leds;
    assign rsp_err        = r_rsp_err;
    assign busy           = r_busy;

endmodule
